cmd_uart_tx_fifo: RTL

Buffered 8N1 UART transmitter for the robot command link. It sits downstream of `command_translator`: it accepts ASCII command bytes on a valid/ready handshake, queues them in a small FIFO, and serialises them onto the GPIO line to the base station. Bursts of multi-byte commands therefore never stall the translator, and bytes offered while the FIFO is full are counted as overflow rather than silently corrupted.

---
 rtl/cmd_uart_tx_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/cmd_uart_tx_fifo.sv
// cmd_uart_tx_fifo: FIFO-buffered 8N1 UART transmitter for the robot command link
// Ports:
//   clk_50      in   system clock
//   reset       in   asynchronous active-high reset
//   data_in     in   command byte
//   data_valid  in   data_in valid this cycle
//   data_ready  out  FIFO not full (combinational)
//   uart_out    out  registered serial line, idle high
//   busy        out  registered, high while a frame is in progress
//   fifo_count  out  bytes queued, excluding the byte in flight
//   overflow    out  sticky, set when a byte is offered while full
module cmd_uart_tx_fifo #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 8
) (
    input  logic                   clk_50,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   uart_out,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_next;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh, sh_next;
    logic push, pop, bit_end, uart_next;

    // Push uses the pre-pop count, so a full FIFO rejects even when a pop coincides
    assign data_ready = fifo_count != FULL;
    assign push = data_valid && data_ready;
    assign pop = state == IDLE && fifo_count != '0;
    assign bit_end = baud_cnt == LAST;

    always_ff @(posedge clk_50 or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_next;

    always_comb begin
        state_next = state == IDLE ? (pop ? START : IDLE) :
                     !bit_end      ? state :
                     state == START ? DATA :
                     state == DATA  ? (bit_idx == 3'd7 ? STOP : DATA) : IDLE;
    end

    // The line is registered from the next state so uart_out comes straight from a flop
    always_comb begin
        sh_next = pop ? mem[rd_ptr] : (state == DATA && bit_end) ? {1'b0, sh[7:1]} : sh;
        uart_next = state_next == START ? 1'b0 : state_next == DATA ? sh_next[0] : 1'b1;
    end

    always_ff @(posedge clk_50)
        if (push)
            mem[wr_ptr] <= data_in;

    always_ff @(posedge clk_50 or posedge reset)
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            sh         <= '0;
            uart_out   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
            overflow   <= overflow | (data_valid & ~data_ready);
            baud_cnt   <= (pop || bit_end) ? '0 : baud_cnt + CW'(1);
            bit_idx    <= pop ? 3'd0 : (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
            sh         <= sh_next;
            uart_out   <= uart_next;
            busy       <= state_next != IDLE;
        end
endmodule
